// File: rtl/mdu_ctrl_pkg.sv
// Shared types and instruction IDs for the multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: E-stage instruction IDs (the lib.v set used by mdu_ctrl), arithmetic op
// selector, commit-accumulate mode, and the packed {HI,LO} pair.
// The madd-family IDs are always declared; mdu_ctrl only decodes them when
// MDU_MADD_EN is defined.
package mdu_ctrl_pkg;

  localparam int unsigned ID_W = 11;

  localparam logic [ID_W-1:0] ID_NOP   = 11'd0;
  localparam logic [ID_W-1:0] ID_ADD   = 11'd1;
  localparam logic [ID_W-1:0] ID_SUB   = 11'd2;
  localparam logic [ID_W-1:0] ID_MFHI  = 11'd16;
  localparam logic [ID_W-1:0] ID_MTHI  = 11'd17;
  localparam logic [ID_W-1:0] ID_MFLO  = 11'd18;
  localparam logic [ID_W-1:0] ID_MTLO  = 11'd19;
  localparam logic [ID_W-1:0] ID_MULT  = 11'd24;
  localparam logic [ID_W-1:0] ID_MULTU = 11'd25;
  localparam logic [ID_W-1:0] ID_DIV   = 11'd26;
  localparam logic [ID_W-1:0] ID_DIVU  = 11'd27;
  localparam logic [ID_W-1:0] ID_MADD  = 11'd28;
  localparam logic [ID_W-1:0] ID_MADDU = 11'd29;
  localparam logic [ID_W-1:0] ID_MSUB  = 11'd30;
  localparam logic [ID_W-1:0] ID_MSUBU = 11'd31;

  typedef enum logic [2:0] {
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU
  } md_op_e;

  // How the pending result is folded into {HI,LO} at commit.
  typedef enum logic [1:0] {
    ACC_NONE, ACC_ADD, ACC_SUB
  } acc_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  function automatic logic is_signed_op(md_op_e op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit multiply/divide result for one MDU op.
// Latency: 0 cycles (pure combinational; the controller models the multi-cycle delay).
// Backpressure: none.
// Ports: op_i (operation), a_i/b_i (rs/rt operands), res_o ({HI,LO} result).
// Division truncates toward zero with the remainder taking the sign of a_i.
// Divide by zero gives LO=all ones, HI=a_i; 0x8000_0000 / -1 gives LO=0x8000_0000, HI=0.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  md_op_e      op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output hilo_t       res_o
);

  logic               sgn;
  logic [63:0]        a_x;
  logic [63:0]        b_x;
  logic [63:0]        prod;
  logic               div_zero;
  logic               div_ovf;
  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic signed [31:0] d_s;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic [31:0]        d_u;
  logic [31:0]        q_u;
  logic [31:0]        r_u;

  always_comb begin
    sgn  = is_signed_op(op_i);
    // Sign/zero extend to 64 bits; the low 64 bits of the product are then exact.
    a_x  = sgn ? {{32{a_i[31]}}, a_i} : {32'b0, a_i};
    b_x  = sgn ? {{32{b_i[31]}}, b_i} : {32'b0, b_i};
    prod = a_x * b_x;

    div_zero = (b_i == 32'd0);
    div_ovf  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

    // Substitute a harmless divisor for the special cases so the dividers never see them.
    a_s = $signed(a_i);
    b_s = $signed(b_i);
    d_s = (div_zero || div_ovf) ? 32'sd1 : b_s;
    q_s = a_s / d_s;
    r_s = a_s % d_s;
    d_u = div_zero ? 32'd1 : b_i;
    q_u = a_i / d_u;
    r_u = a_i % d_u;

    case (op_i)
      OP_DIV: begin
        if (div_zero)     res_o = {a_i, 32'hFFFF_FFFF};
        else if (div_ovf) res_o = {32'd0, 32'h8000_0000};
        else              res_o = {r_s, q_s};
      end
      OP_DIVU: begin
        if (div_zero) res_o = {a_i, 32'hFFFF_FFFF};
        else          res_o = {r_u, q_u};
      end
      default: res_o = prod;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller for the E stage; owns HI/LO.
// Latency: mult/multu MULT_CYCLES, div/divu DIV_CYCLES of busy, then {HI,LO} commits.
// Backpressure: stall is raised for any MDU instruction while busy; non-MDU ops never stall.
// Ports: clk, reset_n (async active-low), instructionID, A, B, flush (in);
//        stall, busy, HI, LO, mdOut (out).
// Optional: define MDU_MADD_EN to add madd/maddu/msub/msubu (accumulate into {HI,LO}).
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [ID_W-1:0] instructionID,
  input  logic [31:0]     A,
  input  logic [31:0]     B,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic [31:0]     HI,
  output logic [31:0]     LO,
  output logic [31:0]     mdOut
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  // Decode
  logic   is_md;
  logic   long_op;
  logic   is_mthi;
  logic   is_mtlo;
  logic   is_mfhi;
  logic   is_mflo;
  logic   any_md;
  logic   issue;
  md_op_e op;
  hilo_t  arith_res;

  // State
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  hilo_t            pend_q, pend_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] count_q, count_d;
`ifdef MDU_MADD_EN
  acc_e             acc_sel;
  acc_e             acc_q, acc_d;
`endif

  always_comb begin
    is_md   = 1'b0;
    long_op = 1'b0;
    op      = OP_MULT;
`ifdef MDU_MADD_EN
    acc_sel = ACC_NONE;
`endif
    case (instructionID)
      ID_MULT:  begin is_md = 1'b1; op = OP_MULT;  end
      ID_MULTU: begin is_md = 1'b1; op = OP_MULTU; end
      ID_DIV:   begin is_md = 1'b1; op = OP_DIV;  long_op = 1'b1; end
      ID_DIVU:  begin is_md = 1'b1; op = OP_DIVU; long_op = 1'b1; end
`ifdef MDU_MADD_EN
      ID_MADD:  begin is_md = 1'b1; op = OP_MADD;  acc_sel = ACC_ADD; end
      ID_MADDU: begin is_md = 1'b1; op = OP_MADDU; acc_sel = ACC_ADD; end
      ID_MSUB:  begin is_md = 1'b1; op = OP_MSUB;  acc_sel = ACC_SUB; end
      ID_MSUBU: begin is_md = 1'b1; op = OP_MSUBU; acc_sel = ACC_SUB; end
`endif
      default: ;
    endcase
    is_mthi = (instructionID == ID_MTHI);
    is_mtlo = (instructionID == ID_MTLO);
    is_mfhi = (instructionID == ID_MFHI);
    is_mflo = (instructionID == ID_MFLO);
    any_md  = is_md | is_mthi | is_mtlo | is_mfhi | is_mflo;
  end

  assign stall = any_md & busy_q;
  assign issue = ~stall & ~flush;

  mdu_arith u_arith (
    .op_i  (op),
    .a_i   (A),
    .b_i   (B),
    .res_o (arith_res)
  );

  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    count_d = count_q;
`ifdef MDU_MADD_EN
    acc_d   = acc_q;
`endif
    if (busy_q) begin
      // An in-flight op always runs to completion; flush cannot cancel it.
      count_d = count_q - 1'b1;
      if (count_q == CNT_W'(1)) begin
        busy_d = 1'b0;
`ifdef MDU_MADD_EN
        // Accumulate against {HI,LO} as it stands at commit, not at start.
        case (acc_q)
          ACC_ADD: {hi_d, lo_d} = {hi_q, lo_q} + pend_q;
          ACC_SUB: {hi_d, lo_d} = {hi_q, lo_q} - pend_q;
          default: {hi_d, lo_d} = pend_q;
        endcase
`else
        {hi_d, lo_d} = pend_q;
`endif
      end
    end else if (is_md && issue) begin
      pend_d  = arith_res;
      count_d = long_op ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      busy_d  = 1'b1;
`ifdef MDU_MADD_EN
      acc_d   = acc_sel;
`endif
    end else if (issue) begin
      if (is_mthi) hi_d = A;
      if (is_mtlo) lo_d = A;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
`ifdef MDU_MADD_EN
      acc_q   <= ACC_NONE;
`endif
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      count_q <= count_d;
`ifdef MDU_MADD_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign HI    = hi_q;
  assign LO    = lo_q;
  assign mdOut = is_mfhi ? hi_q : (is_mflo ? lo_q : 32'd0);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Testbench for mdu_ctrl: directed cases plus randomized instruction stream.
// Reference model tracks architectural HI/LO and the cycle at which busy ends.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic            clk;
  logic            reset_n;
  logic [ID_W-1:0] instructionID;
  logic [31:0]     A;
  logic [31:0]     B;
  logic            flush;
  logic            stall;
  logic            busy;
  logic [31:0]     HI;
  logic [31:0]     LO;
  logic [31:0]     mdOut;

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .instructionID (instructionID),
    .A             (A),
    .B             (B),
    .flush         (flush),
    .stall         (stall),
    .busy          (busy),
    .HI            (HI),
    .LO            (LO),
    .mdOut         (mdOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_pend = '0;
  int          m_kind = 0;   // 0 replace, 1 add, 2 subtract
  longint      m_done = 0;   // first cycle in which busy is low again
  longint      cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic madd_family(logic [ID_W-1:0] id);
`ifdef MDU_MADD_EN
    return id == ID_MADD || id == ID_MADDU || id == ID_MSUB || id == ID_MSUBU;
`else
    return (id == ID_MADD) && 1'b0;
`endif
  endfunction

  function automatic logic m_is_start(logic [ID_W-1:0] id);
    return id == ID_MULT || id == ID_MULTU || id == ID_DIV || id == ID_DIVU || madd_family(id);
  endfunction

  function automatic logic m_any(logic [ID_W-1:0] id);
    return m_is_start(id) || id == ID_MTHI || id == ID_MTLO || id == ID_MFHI || id == ID_MFLO;
  endfunction

  function automatic logic [63:0] m_result(logic [ID_W-1:0] id, logic [31:0] a, logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] res;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = '0;
    if (id == ID_MULT || id == ID_MADD || id == ID_MSUB) res = sa * sb;
    else if (id == ID_MULTU || id == ID_MADDU || id == ID_MSUBU) res = ua * ub;
    else if (id == ID_DIV) begin
      if (b == 0) res = {a, 32'hFFFF_FFFF};
      else begin
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
    end else if (id == ID_DIVU) begin
      if (b == 0) res = {a, 32'hFFFF_FFFF};
      else res = {32'(ua % ub), 32'(ua / ub)};
    end
    return res;
  endfunction

  // One clock cycle: drive at negedge, compare mid-cycle, advance model to the next edge.
  task automatic step(input logic [ID_W-1:0] id, input logic [31:0] a, input logic [31:0] b,
                      input logic fl, input logic rn);
    logic        e_busy, e_stall;
    logic [31:0] e_md;
    @(negedge clk);
    instructionID = id;
    A = a;
    B = b;
    flush = fl;
    reset_n = rn;
    #1;
    if (!rn) begin
      m_hi = '0; m_lo = '0; m_pend = '0; m_done = 0;
    end
    e_busy  = (cyc < m_done);
    e_stall = m_any(id) && e_busy;
    e_md    = (id == ID_MFHI) ? m_hi : ((id == ID_MFLO) ? m_lo : 32'd0);
    chk("busy",  32'(busy),  32'(e_busy));
    chk("stall", 32'(stall), 32'(e_stall));
    chk("mdOut", mdOut, e_md);
    chk("HI", HI, m_hi);
    chk("LO", LO, m_lo);
    if (rn) begin
      if (e_busy && cyc == m_done - 1) begin
        if (m_kind == 1)      {m_hi, m_lo} = {m_hi, m_lo} + m_pend;
        else if (m_kind == 2) {m_hi, m_lo} = {m_hi, m_lo} - m_pend;
        else                  {m_hi, m_lo} = m_pend;
      end
      if (!e_stall && !fl) begin
        if (m_is_start(id)) begin
          m_pend = m_result(id, a, b);
          m_kind = (id == ID_MADD || id == ID_MADDU) ? 1 :
                   (id == ID_MSUB || id == ID_MSUBU) ? 2 : 0;
          m_done = cyc + ((id == ID_DIV || id == ID_DIVU) ? DIV_N : MULT_N) + 1;
        end else if (id == ID_MTHI) m_hi = a;
        else if (id == ID_MTLO) m_lo = a;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n, output int nbusy);
    nbusy = 0;
    for (int i = 0; i < n; i++) begin
      step(ID_NOP, 32'd0, 32'd0, 1'b0, 1'b1);
      nbusy += int'(busy);
    end
  endtask

  function automatic logic [31:0] rand_opnd();
    int s;
    s = $urandom_range(0, 7);
    case (s)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [ID_W-1:0] pool [$];

  initial begin
    int nb;
    int nstall;
    logic [ID_W-1:0] id;
    instructionID = ID_NOP; A = '0; B = '0; flush = 1'b0; reset_n = 1'b0;

    // Reset state
    step(ID_NOP, 32'd0, 32'd0, 1'b0, 1'b0);
    step(ID_MFHI, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("reset_busy", 32'(busy), 32'd0);

    // mult -3*7, mfhi behind it stalls for the whole operation
    step(ID_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b1);
    nstall = 0;
    for (int i = 0; i < MULT_N + 1; i++) begin
      step(ID_MFHI, 32'd0, 32'd0, 1'b0, 1'b1);
      nstall += int'(stall);
    end
    chk("mfhi_stall_cycles", 32'(nstall), 32'd5);
    chk("mfhi_value", mdOut, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFEB);

    // divu 100/7
    step(ID_DIVU, 32'd100, 32'd7, 1'b0, 1'b1);
    idle(DIV_N + 1, nb);
    chk("divu_busy_cycles", 32'(nb), 32'd10);
    chk("divu_lo", LO, 32'd14);
    chk("divu_hi", HI, 32'd2);

    // div -7/2
    step(ID_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
    idle(DIV_N + 1, nb);
    chk("div_neg_lo", LO, 32'hFFFF_FFFD);
    chk("div_neg_hi", HI, 32'hFFFF_FFFF);

    // div overflow
    step(ID_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    idle(DIV_N + 1, nb);
    chk("div_ovf_lo", LO, 32'h8000_0000);
    chk("div_ovf_hi", HI, 32'd0);

    // div by zero
    step(ID_DIV, 32'd5, 32'd0, 1'b0, 1'b1);
    idle(DIV_N + 1, nb);
    chk("div0_busy_cycles", 32'(nb), 32'd10);
    chk("div0_lo", LO, 32'hFFFF_FFFF);
    chk("div0_hi", HI, 32'd5);

    // flushed mthi and mult have no effect
    step(ID_MTHI, 32'h1234, 32'd0, 1'b1, 1'b1);
    step(ID_NOP, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("mthi_flush_hi", HI, 32'd5);
    step(ID_MULT, 32'd3, 32'd3, 1'b1, 1'b1);
    step(ID_NOP, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("mult_flush_busy", 32'(busy), 32'd0);

    // flush mid-div does not cancel it
    step(ID_DIV, 32'd20, 32'd3, 1'b0, 1'b1);
    idle(3, nb);
    step(ID_NOP, 32'd0, 32'd0, 1'b1, 1'b1);
    step(ID_DIV, 32'd1, 32'd1, 1'b1, 1'b1);
    idle(DIV_N - 4, nb);
    chk("flush_div_lo", LO, 32'd6);
    chk("flush_div_hi", HI, 32'd2);

    // non-MDU op during busy
    step(ID_MULTU, 32'd9, 32'd9, 1'b0, 1'b1);
    step(ID_ADD, 32'd1, 32'd2, 1'b0, 1'b1);
    chk("alu_no_stall", 32'(stall), 32'd0);
    idle(MULT_N, nb);
    chk("multu_lo", LO, 32'd81);

    // reset in the middle of a div
    step(ID_DIV, 32'd50, 32'd3, 1'b0, 1'b1);
    idle(2, nb);
    step(ID_NOP, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_lo", LO, 32'd0);
    step(ID_NOP, 32'd0, 32'd0, 1'b0, 1'b1);
    idle(DIV_N, nb);
    chk("rst_no_commit", LO, 32'd0);

`ifdef MDU_MADD_EN
    step(ID_MTHI, 32'd0, 32'd0, 1'b0, 1'b1);
    step(ID_MTLO, 32'd10, 32'd0, 1'b0, 1'b1);
    step(ID_MADD, 32'd3, 32'd4, 1'b0, 1'b1);
    idle(MULT_N + 1, nb);
    chk("madd_lo", LO, 32'd22);
    step(ID_MTLO, 32'd0, 32'd0, 1'b0, 1'b1);
    step(ID_MSUBU, 32'd5, 32'd5, 1'b0, 1'b1);
    idle(MULT_N + 1, nb);
    chk("msubu_hi", HI, 32'hFFFF_FFFF);
    chk("msubu_lo", LO, 32'hFFFF_FFE7);
`else
    step(ID_MADD, 32'd3, 32'd4, 1'b0, 1'b1);
    step(ID_NOP, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("madd_off_busy", 32'(busy), 32'd0);
`endif

    // Randomized stream
    pool = '{ID_ADD, ID_SUB, ID_MULT, ID_MULTU, ID_DIV, ID_DIVU, ID_MFHI, ID_MFLO,
             ID_MTHI, ID_MTLO, ID_MADD, ID_MADDU, ID_MSUB, ID_MSUBU};
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 35) id = ID_NOP;
      else id = pool[$urandom_range(0, pool.size() - 1)];
      step(id, rand_opnd(), rand_opnd(), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 299) != 0));
    end
    idle(DIV_N + 2, nb);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
